ir_fetch_sequencer: RTL and testbench
=====================================

// Module: ir_fetch_sequencer
// PURPOSE
//  Fetches one 16-bit instruction from byte-wide memory into the InstructionRegister.
//  Sequence: read byte at PC into IR[7:0] (LH=0), then byte at PC+1 into IR[15:8] (LH=1).
//  Owns the program counter and the memory request/acknowledge handshake.
//  Sits between the control unit (Start/Done) and the memory/IR datapath.
// PARAMETERS
//  ADDR_WIDTH  16   width of PC and memory address
//  RESET_PC    0    PC value after reset
//  TIMEOUT     15   max REQ-state cycles without MemAck before fault (>=1)
// PORTS
//  Clock    in   1           rising-edge clock
//  Reset    in   1           synchronous, active-high reset
//  Start    in   1           fetch request; sampled in IDLE only
//  PCLoad   in   1           load PC from PCIn; honoured in IDLE only
//  PCIn     in   ADDR_WIDTH  new PC value
//  MemReq   out  1           memory read request
//  MemAddr  out  ADDR_WIDTH  read address; equals PC
//  MemAck   in   1           read data valid this cycle
//  MemData  in   8           read data
//  IRWrite  out  1           to IR Write
//  IRLH     out  1           to IR LH (0 = low byte, 1 = high byte)
//  IRData   out  8           to IR I; registered byte
//  PCOut    out  ADDR_WIDTH  current PC
//  Busy     out  1           high in any state other than IDLE
//  Done     out  1           one-cycle pulse; high-byte write in progress
//  Fault    out  1           one-cycle pulse after memory timeout
// BEHAVIOUR
//  Reset:
//   - state=IDLE; PC=RESET_PC; IRData=0; timer=0.
//   - Outputs are 0 from the cycle after Reset is sampled high.
//   - PCOut=RESET_PC.
//   - Reset dominates every other input, including mid-fetch. A partial IR write stays as is.
//  States (Moore outputs):
//   - IDLE:
//     - PCLoad=1 -> PC<=PCIn; Start is ignored that cycle.
//     - Else Start=1 -> save PC to StartPC; timer<=0; go to REQ_LO.
//   - REQ_LO:
//     - MemReq=1; MemAddr=PC held stable.
//     - MemAck=1 -> IRData<=MemData; go to WR_LO.
//   - WR_LO:
//     - IRWrite=1, IRLH=0.
//     - PC<=PC+1 (mod 2^ADDR_WIDTH); timer<=0; go to REQ_HI.
//   - REQ_HI:
//     - Same as REQ_LO; MemAck -> IRData<=MemData; go to WR_HI.
//   - WR_HI:
//     - IRWrite=1, IRLH=1, Done=1.
//     - PC<=PC+1; go to IDLE. IR holds the full word from the next cycle.
//  Timeout:
//   - timer increments each REQ cycle with MemAck=0.
//   - TIMEOUT-th REQ cycle with no ack -> PC<=StartPC, go to IDLE.
//   - Fault=1 for the following cycle; no further IR write.
//  Ignored inputs:
//   - MemAck outside the REQ states; Start/PCLoad while Busy.
//   - Start held high re-triggers in IDLE.
//  Latency:
//   - Zero-wait memory: Start sampled at cycle 0 -> Done at cycle 4.
//   - Next Start accepted at cycle 5.
//   - Each memory wait cycle adds 1.
//  PC increment wraps; the high byte of an instruction at the top address is read from address 0.
// TESTING
//  1. Reset 2 cycles -> PCOut=0, Busy=0, MemReq=0, IRWrite=0, Done=0, Fault=0.
//  2. PCLoad 0x0040; Start; zero-wait mem [0x40]=0x34, [0x41]=0x12
//     -> cycle 2 write LH=0 0x34; cycle 4 write LH=1 0x12 with Done; IR=0x1234; PCOut=0x0042.
//  3. As test 2 with 3 wait cycles per byte -> Done at cycle 10; MemAddr stable during each REQ.
//  4. No MemAck on high byte, TIMEOUT=15 -> Fault pulse, single LH=0 write only,
//     PCOut=0x0040, Busy=0.
//  5. PCLoad 0xFFFF; Start -> reads 0xFFFF then 0x0000; PCOut=0x0001.
//  6. Start+PCLoad same cycle -> PC loaded, no MemReq.
//     Reset during REQ_HI -> IDLE, PCOut=0, no LH=1 write.

Source files
------------

// File: rtl/ir_fetch_sequencer.sv
// ir_fetch_sequencer
//   Fetches one 16-bit instruction from a byte-wide memory into the instruction
//   register. The low byte is read from PC, then the high byte from PC+1. The
//   block owns the program counter and the memory request/acknowledge handshake.
//   If memory never acknowledges, the block gives up, restores the PC and pulses
//   Fault.
//
// Ports
//   Clock    in   rising-edge clock
//   Reset    in   synchronous, active-high reset
//   Start    in   fetch request, sampled in IDLE only
//   PCLoad   in   load PC from PCIn, honoured in IDLE only (wins over Start)
//   PCIn     in   new PC value
//   MemReq   out  memory read request
//   MemAddr  out  read address (always the current PC)
//   MemAck   in   read data valid this cycle
//   MemData  in   read data byte
//   IRWrite  out  IR write strobe
//   IRLH     out  IR byte select (0 = low byte, 1 = high byte)
//   IRData   out  registered byte for the IR
//   PCOut    out  current PC
//   Busy     out  high in any state other than IDLE
//   Done     out  one-cycle pulse while the high byte is written
//   Fault    out  one-cycle pulse after a memory timeout
//
// state    | meaning
// S_IDLE   | waiting for Start; PCLoad accepted here
// S_REQ_LO | requesting the low byte at PC
// S_WR_LO  | writing the low byte to IR; PC advances
// S_REQ_HI | requesting the high byte at PC
// S_WR_HI  | writing the high byte to IR with Done; PC advances
module ir_fetch_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           TIMEOUT    = 15
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  PCLoad,
  input  logic [ADDR_WIDTH-1:0] PCIn,
  output logic                  MemReq,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemAck,
  input  logic [7:0]            MemData,
  output logic                  IRWrite,
  output logic                  IRLH,
  output logic [7:0]            IRData,
  output logic [ADDR_WIDTH-1:0] PCOut,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Fault
);

  // The timeout timer counts down from TIMEOUT-1; a REQ cycle without ack
  // that finds it at zero is the TIMEOUT-th such cycle.
  localparam int unsigned           TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]         TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]         TMR_ONE  = TW'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_WR_LO,
    S_REQ_HI,
    S_WR_HI
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pc, pc_nxt;
  logic [ADDR_WIDTH-1:0]   start_pc, start_pc_nxt;
  logic [7:0]              ir_data, ir_data_nxt;
  logic [TW-1:0]           timer, timer_nxt;
  logic                    fault_q, fault_nxt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      start_pc <= RESET_PC;
      ir_data  <= 8'h00;
      timer    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      start_pc <= start_pc_nxt;
      ir_data  <= ir_data_nxt;
      timer    <= timer_nxt;
      fault_q  <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    start_pc_nxt = start_pc;
    ir_data_nxt  = ir_data;
    timer_nxt    = timer;
    fault_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (PCLoad) begin
          pc_nxt = PCIn;
        end else if (Start) begin
          start_pc_nxt = pc;
          timer_nxt    = TMR_LOAD;
          state_nxt    = S_REQ_LO;
        end
      end

      S_REQ_LO, S_REQ_HI: begin
        // An ack on the last allowed cycle still completes the read.
        if (MemAck) begin
          ir_data_nxt = MemData;
          state_nxt   = (state == S_REQ_LO) ? S_WR_LO : S_WR_HI;
        end else if (timer == '0) begin
          // Abandon the whole fetch, including a completed low byte.
          pc_nxt    = start_pc;
          fault_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer - TMR_ONE;
        end
      end

      S_WR_LO: begin
        pc_nxt    = pc + PC_ONE;
        timer_nxt = TMR_LOAD;
        state_nxt = S_REQ_HI;
      end

      S_WR_HI: begin
        pc_nxt    = pc + PC_ONE;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded straight from the state register so that MemReq
  // never depends combinationally on MemAck.
  assign MemReq  = (state == S_REQ_LO) || (state == S_REQ_HI);
  assign MemAddr = pc;
  assign PCOut   = pc;
  assign IRWrite = (state == S_WR_LO) || (state == S_WR_HI);
  assign IRLH    = (state == S_WR_HI);
  assign Done    = (state == S_WR_HI);
  assign Busy    = (state != S_IDLE);
  assign IRData  = ir_data;
  assign Fault   = fault_q;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
module tb_ir_fetch_sequencer;

  localparam int T = 15;

  logic        Clock = 1'b0;
  logic        Reset, Start, PCLoad, MemAck, MemReq;
  logic [15:0] PCIn, MemAddr, PCOut;
  logic [7:0]  MemData, IRData;
  logic        IRWrite, IRLH, Busy, Done, Fault;

  ir_fetch_sequencer #(.ADDR_WIDTH(16), .RESET_PC(16'h0000), .TIMEOUT(T)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PCLoad(PCLoad), .PCIn(PCIn),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .IRWrite(IRWrite), .IRLH(IRLH), .IRData(IRData), .PCOut(PCOut),
    .Busy(Busy), .Done(Done), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  // Memory model: acknowledges after cur_wait wait cycles of an active request.
  logic [7:0] mem [0:65535];
  int         req_cnt  = 0;
  int         cur_wait = 0;
  logic       stray_ack = 1'b0;

  always @(posedge Clock) begin
    if (MemReq && !MemAck) req_cnt <= req_cnt + 1;
    else                   req_cnt <= 0;
  end

  assign MemAck  = MemReq ? (req_cnt >= cur_wait) : stray_ack;
  assign MemData = MemReq ? mem[MemAddr] : 8'hEE;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          writes;
    int          lo_cyc;
    int          done_cyc;
    int          fault_cyc;
    int          end_cyc;
    logic [15:0] word;
    logic [15:0] pc;
    bit          addr_bad;
  } obs_t;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          wlo;
    int          whi;
    obs_t        exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_obs(input string tag, input obs_t o, input obs_t e);
    chk($sformatf("%s.writes", tag),    o.writes,    e.writes);
    chk($sformatf("%s.lo_cyc", tag),    o.lo_cyc,    e.lo_cyc);
    chk($sformatf("%s.done_cyc", tag),  o.done_cyc,  e.done_cyc);
    chk($sformatf("%s.fault_cyc", tag), o.fault_cyc, e.fault_cyc);
    chk($sformatf("%s.end_cyc", tag),   o.end_cyc,   e.end_cyc);
    chk($sformatf("%s.word", tag),      {16'h0, o.word}, {16'h0, e.word});
    chk($sformatf("%s.pc", tag),        {16'h0, o.pc},   {16'h0, e.pc});
    chk($sformatf("%s.addr_stable", tag), {31'h0, o.addr_bad}, 32'h0);
  endtask

  // Reference: outcome of one fetch from the fetch rules, as plain arithmetic
  // over the wait counts (cycle 0 = the cycle Start is sampled).
  function automatic obs_t model(input logic [15:0] p, input int wlo, input int whi,
                                 input logic [7:0] lo, input logic [7:0] hi);
    obs_t e;
    e.writes = 0; e.lo_cyc = 0; e.done_cyc = 0; e.fault_cyc = 0;
    e.end_cyc = 0; e.word = 16'h0; e.pc = p; e.addr_bad = 1'b0;
    if (wlo >= T) begin
      e.fault_cyc = 1 + T;
      e.end_cyc   = 1 + T;
    end else begin
      e.writes = 1;
      e.lo_cyc = 2 + wlo;
      e.word   = {8'h00, lo};
      if (whi >= T) begin
        e.fault_cyc = 3 + wlo + T;
        e.end_cyc   = 3 + wlo + T;
      end else begin
        e.writes   = 2;
        e.done_cyc = 4 + wlo + whi;
        e.end_cyc  = 5 + wlo + whi;
        e.word     = {hi, lo};
        e.pc       = p + 16'd2;
      end
    end
    return e;
  endfunction

  task automatic load_pc(input logic [15:0] v);
    PCLoad = 1'b1;
    PCIn   = v;
    @(negedge Clock);
    PCLoad = 1'b0;
  endtask

  // Called at a negedge with the DUT idle and PC == p. Returns at the first
  // negedge where Busy is low again.
  task automatic run_fetch(input logic [15:0] p, input int wlo, input int whi,
                           input bit noise, output obs_t o);
    int cyc;
    bit fin;
    o.writes = 0; o.lo_cyc = 0; o.done_cyc = 0; o.fault_cyc = 0;
    o.end_cyc = -1; o.word = 16'h0; o.pc = 16'h0; o.addr_bad = 1'b0;
    cur_wait = wlo;
    Start = 1'b1;
    @(posedge Clock);
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 100) begin
      @(negedge Clock);
      cyc++;
      if (MemReq && MemAddr !== ((o.writes == 0) ? p : p + 16'd1)) o.addr_bad = 1'b1;
      if (IRWrite) begin
        if (!IRLH) begin
          o.lo_cyc     = cyc;
          o.word[7:0]  = IRData;
          cur_wait     = whi;
        end else begin
          o.word[15:8] = IRData;
        end
        o.writes++;
      end
      if (Done)  o.done_cyc  = cyc;
      if (Fault) o.fault_cyc = cyc;
      if (!Busy) begin
        fin       = 1'b1;
        o.end_cyc = cyc;
        o.pc      = PCOut;
      end
      if (fin || !noise) begin
        Start = 1'b0; PCLoad = 1'b0; stray_ack = 1'b0;
      end else begin
        Start     = 1'($urandom_range(0, 1));
        PCLoad    = 1'($urandom_range(0, 1));
        PCIn      = 16'($urandom);
        stray_ack = 1'($urandom_range(0, 1));
      end
    end
    Start = 1'b0; PCLoad = 1'b0; stray_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[8];
    obs_t        o, e;
    logic [15:0] p, p1;
    int          d1, d2, nw, wlo, whi;

    vecs[0] = '{16'h0040, 8'h34, 8'h12, 0,  0,  '{2, 2,  4,  0,  5,  16'h1234, 16'h0042, 1'b0}};
    vecs[1] = '{16'h0040, 8'h34, 8'h12, 3,  3,  '{2, 5,  10, 0,  11, 16'h1234, 16'h0042, 1'b0}};
    vecs[2] = '{16'h0040, 8'h34, 8'h12, 0,  99, '{1, 2,  0,  18, 18, 16'h0034, 16'h0040, 1'b0}};
    vecs[3] = '{16'hFFFF, 8'hCD, 8'hAB, 0,  0,  '{2, 2,  4,  0,  5,  16'hABCD, 16'h0001, 1'b0}};
    vecs[4] = '{16'h1234, 8'h5A, 8'hA5, 14, 0,  '{2, 16, 18, 0,  19, 16'hA55A, 16'h1236, 1'b0}};
    vecs[5] = '{16'h1234, 8'h5A, 8'hA5, 15, 0,  '{0, 0,  0,  16, 16, 16'h0000, 16'h1234, 1'b0}};
    vecs[6] = '{16'h0100, 8'h01, 8'h80, 2,  14, '{2, 4,  20, 0,  21, 16'h8001, 16'h0102, 1'b0}};
    vecs[7] = '{16'h0100, 8'h01, 8'h80, 2,  15, '{1, 4,  0,  20, 20, 16'h0001, 16'h0100, 1'b0}};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    Reset = 1'b1; Start = 1'b0; PCLoad = 1'b0; PCIn = 16'h0;

    // Reset state
    repeat (2) @(negedge Clock);
    chk("rst.PCOut",   {16'h0, PCOut}, 32'h0);
    chk("rst.Busy",    {31'h0, Busy}, 32'h0);
    chk("rst.MemReq",  {31'h0, MemReq}, 32'h0);
    chk("rst.IRWrite", {31'h0, IRWrite}, 32'h0);
    chk("rst.Done",    {31'h0, Done}, 32'h0);
    chk("rst.Fault",   {31'h0, Fault}, 32'h0);
    chk("rst.IRData",  {24'h0, IRData}, 32'h0);
    Reset = 1'b0;
    @(negedge Clock);

    // Start and PCLoad together: load wins, no fetch begins
    Start = 1'b1; PCLoad = 1'b1; PCIn = 16'h2222;
    @(negedge Clock);
    Start = 1'b0; PCLoad = 1'b0;
    chk("startload.PCOut",  {16'h0, PCOut}, 32'h2222);
    chk("startload.Busy",   {31'h0, Busy}, 32'h0);
    chk("startload.MemReq", {31'h0, MemReq}, 32'h0);
    @(negedge Clock);
    chk("startload.MemReq2", {31'h0, MemReq}, 32'h0);

    // Start held high re-triggers as soon as the block is idle again
    load_pc(16'h0500);
    cur_wait = 0;
    d1 = 0; d2 = 0;
    Start = 1'b1;
    @(posedge Clock);
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clock);
      if (Done) begin
        if (d1 == 0) d1 = c;
        else         d2 = c;
      end
      if (c == 9) Start = 1'b0;
    end
    @(negedge Clock);
    chk("retrig.done1", d1, 4);
    chk("retrig.done2", d2, 9);
    chk("retrig.PCOut", {16'h0, PCOut}, 32'h0504);
    chk("retrig.Busy",  {31'h0, Busy}, 32'h0);

    // Table-driven fetches with hand-computed results
    for (int i = 0; i < 8; i++) begin
      p  = vecs[i].pc;
      p1 = p + 16'd1;
      mem[p]  = vecs[i].lo;
      mem[p1] = vecs[i].hi;
      load_pc(p);
      run_fetch(p, vecs[i].wlo, vecs[i].whi, 1'b0, o);
      cmp_obs($sformatf("vec%0d", i), o, vecs[i].exp);
    end

    // Reset while waiting for the high byte
    load_pc(16'h0300);
    cur_wait = 0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    cur_wait = 99;
    @(negedge Clock);
    chk("midrst.MemReq_before",  {31'h0, MemReq}, 32'h1);
    chk("midrst.MemAddr_before", {16'h0, MemAddr}, 32'h0301);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("midrst.Busy",    {31'h0, Busy}, 32'h0);
    chk("midrst.PCOut",   {16'h0, PCOut}, 32'h0);
    chk("midrst.MemReq",  {31'h0, MemReq}, 32'h0);
    chk("midrst.IRWrite", {31'h0, IRWrite}, 32'h0);
    nw = 0;
    repeat (4) begin
      @(negedge Clock);
      if (IRWrite) nw++;
    end
    chk("midrst.no_write", nw, 0);
    cur_wait = 0;

    // Randomized fetches against the reference model
    p = 16'h0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) p = 16'(16'hFFFF - 16'($urandom_range(0, 1)));
        else                           p = 16'($urandom);
        load_pc(p);
      end
      wlo = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(13, 17));
      whi = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(13, 17));
      p1 = p + 16'd1;
      e  = model(p, wlo, whi, mem[p], mem[p1]);
      run_fetch(p, wlo, whi, 1'b1, o);
      cmp_obs($sformatf("rnd%0d", i), o, e);
      p = e.pc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
